pixel_mixer: RTL

Per-pixel colour back end of the GBC PPU. It accepts one background pixel and one optional sprite pixel per transfer and drives the color file's palette-lookup ports. It resolves BG/sprite priority, converts the chosen 15-bit GBC colour to RGB888, and buffers results in a small FIFO. The FIFO feeds the frame-buffer writer over a valid/ready handshake.

---
 rtl/gbc_pix_pkg.sv | 51 +++++
 rtl/pixel_mixer_fifo.sv | 70 +++++++
 rtl/pixel_mixer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/gbc_pix_pkg.sv
// gbc_pix_pkg
//   Shared types and helpers for the GBC per-pixel colour back end.
//   - fifo_entry_t     : one output FIFO entry, {rgb[23:0], last}
//   - expand5          : 5-bit to 8-bit colour channel expansion
//   - gbc_to_rgb888    : colour-file lookup word to packed {R,G,B} 8:8:8
//   - sprite_wins      : BG/sprite priority resolution
package gbc_pix_pkg;

  typedef struct packed {
    logic [23:0] rgb;
    logic        last;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  // Replicating the top bits into the low bits maps 0x00->0x00 and 0x1F->0xFF
  // with an even spread in between.
  function automatic logic [7:0] expand5(input logic [4:0] x5);
    return {x5, x5[4:2]};
  endfunction

  // The colour file returns {even byte, odd byte}, so the little-endian
  // RGB555 word is byte-swapped here: R and B sit in whole bytes, G straddles
  // both bytes. Colour bit 15 (c[7]) carries no colour information.
  function automatic logic [23:0] gbc_to_rgb888(input logic [15:0] c);
    logic [4:0] r5;
    logic [4:0] g5;
    logic [4:0] b5;
    logic       unused_b15;
    r5         = c[12:8];
    g5         = {c[1:0], c[15:13]};
    b5         = c[6:2];
    unused_b15 = c[7];
    return {expand5(r5), expand5(g5), expand5(b5)};
  endfunction

  // A present, non-transparent sprite wins unless an opaque BG pixel claims
  // priority (either attribute bit) while the LCDC master priority is enabled.
  function automatic logic sprite_wins(
    input logic       spr_present,
    input logic [1:0] spr_idx,
    input logic [1:0] bg_idx,
    input logic       bg_prio,
    input logic       spr_prio,
    input logic       master_prio
  );
    return spr_present && (spr_idx != 2'd0) &&
           (!master_prio || (bg_idx == 2'd0) || (!bg_prio && !spr_prio));
  endfunction

endpackage

// File: rtl/pixel_mixer_fifo.sv
// pixel_fifo
//   Parameterised synchronous first-word-fall-through FIFO.
//   DEPTH must be a power of two (pointers wrap by natural overflow), >= 2.
// Ports
//   I_CLK, I_RESET : clock, synchronous active-high reset (clears contents)
//   wr_en, wr_data : write request; ignored when full unless a pop coincides
//   rd_en          : pop the head when rd_valid is high
//   rd_data        : head entry (valid while rd_valid)
//   rd_valid       : FIFO not empty
//   count          : number of stored entries, 0..DEPTH
module pixel_fifo #(
  parameter  int WIDTH = 25,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             I_CLK,
  input  logic             I_RESET,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign rd_valid = (count != '0);
  assign pop      = rd_en && rd_valid;
  // Writing into a full FIFO is only legal when the head leaves at the same edge.
  assign push     = wr_en && ((count != CW'(DEPTH)) || pop);
  assign rd_data  = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_mixer.sv
// pixel_mixer
//   Per-pixel colour back end of the GBC PPU. Captures one BG pixel plus an
//   optional sprite pixel into stage 1, drives the colour-file palette
//   lookups from that stage, resolves priority, converts the winning RGB555
//   colour to RGB888 and queues {rgb, last} in an output FWFT FIFO.
// Ports
//   I_CLK, I_RESET                 : clock, synchronous active-high reset
//   I_PIX_VALID / O_PIX_READY      : pixel input handshake
//   I_PIX_LAST                     : scanline end, carried to O_RGB_LAST
//   I_BG_PAL/IDX/PRIO              : BG palette, colour index, attribute prio
//   I_SPR_PRESENT/PAL/IDX/PRIO     : sprite pixel fields (PRIO = behind BG)
//   I_MASTER_PRIO                  : LCDC bit 0
//   O_BGPAL_SEL/INDEX, I_BGPAL_COLOR   : BG palette lookup (combinational)
//   O_SPRPAL_SEL/INDEX, I_SPRPAL_COLOR : sprite palette lookup (combinational)
//   O_RGB, O_RGB_LAST, O_RGB_VALID / I_RGB_READY : output stream
//
// Handshakes: a transfer happens at a rising edge where valid and ready are
// both high. Valid never depends on ready; once raised, valid and payload stay
// stable until the transfer. O_PIX_READY and O_RGB_VALID depend on registers
// only.
module pixel_mixer
  import gbc_pix_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_PIX_VALID,
  output logic        O_PIX_READY,
  input  logic        I_PIX_LAST,
  input  logic [2:0]  I_BG_PAL,
  input  logic [1:0]  I_BG_IDX,
  input  logic        I_BG_PRIO,
  input  logic        I_SPR_PRESENT,
  input  logic [2:0]  I_SPR_PAL,
  input  logic [1:0]  I_SPR_IDX,
  input  logic        I_SPR_PRIO,
  input  logic        I_MASTER_PRIO,
  output logic [2:0]  O_BGPAL_SEL,
  output logic [1:0]  O_BGPAL_INDEX,
  output logic [2:0]  O_SPRPAL_SEL,
  output logic [1:0]  O_SPRPAL_INDEX,
  input  logic [15:0] I_BGPAL_COLOR,
  input  logic [15:0] I_SPRPAL_COLOR,
  output logic [23:0] O_RGB,
  output logic        O_RGB_LAST,
  output logic        O_RGB_VALID,
  input  logic        I_RGB_READY
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Stage 1 pixel register
  logic       s1_valid;
  logic [2:0] s1_bg_pal;
  logic [1:0] s1_bg_idx;
  logic       s1_bg_prio;
  logic       s1_spr_present;
  logic [2:0] s1_spr_pal;
  logic [1:0] s1_spr_idx;
  logic       s1_spr_prio;
  logic       s1_master;
  logic       s1_last;

  logic          accept;
  logic          spr_sel;
  logic [15:0]   chosen_color;
  fifo_entry_t   wr_entry;
  fifo_entry_t   head_entry;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credits_used;

  // Credit flow control: every pixel in s1 already owns a FIFO slot, so s1
  // can always drain into the FIFO at the next edge without a stall path.
  assign credits_used = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid};
  assign O_PIX_READY  = (credits_used < (CW + 1)'(FIFO_DEPTH));
  assign accept       = I_PIX_VALID && O_PIX_READY;

  // Fields load only on acceptance, so the lookup ports hold their last value
  // while s1 is empty.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      s1_valid       <= 1'b0;
      s1_bg_pal      <= '0;
      s1_bg_idx      <= '0;
      s1_bg_prio     <= 1'b0;
      s1_spr_present <= 1'b0;
      s1_spr_pal     <= '0;
      s1_spr_idx     <= '0;
      s1_spr_prio    <= 1'b0;
      s1_master      <= 1'b0;
      s1_last        <= 1'b0;
    end else if (accept) begin
      s1_valid       <= 1'b1;
      s1_bg_pal      <= I_BG_PAL;
      s1_bg_idx      <= I_BG_IDX;
      s1_bg_prio     <= I_BG_PRIO;
      s1_spr_present <= I_SPR_PRESENT;
      s1_spr_pal     <= I_SPR_PAL;
      s1_spr_idx     <= I_SPR_IDX;
      s1_spr_prio    <= I_SPR_PRIO;
      s1_master      <= I_MASTER_PRIO;
      s1_last        <= I_PIX_LAST;
    end else begin
      s1_valid       <= 1'b0;
    end
  end

  assign O_BGPAL_SEL    = s1_bg_pal;
  assign O_BGPAL_INDEX  = s1_bg_idx;
  assign O_SPRPAL_SEL   = s1_spr_pal;
  assign O_SPRPAL_INDEX = s1_spr_idx;

  // Stage 2: the colour file answers within the cycle, so priority, decode
  // and the FIFO write all happen on the edge that retires s1.
  always_comb begin
    spr_sel = sprite_wins(s1_spr_present, s1_spr_idx, s1_bg_idx,
                          s1_bg_prio, s1_spr_prio, s1_master);
    chosen_color  = spr_sel ? I_SPRPAL_COLOR : I_BGPAL_COLOR;
    wr_entry.rgb  = gbc_to_rgb888(chosen_color);
    wr_entry.last = s1_last;
  end

  pixel_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .I_CLK    (I_CLK),
    .I_RESET  (I_RESET),
    .wr_en    (s1_valid),
    .wr_data  (wr_entry),
    .rd_en    (I_RGB_READY),
    .rd_data  (head_entry),
    .rd_valid (O_RGB_VALID),
    .count    (fifo_count)
  );

  assign O_RGB      = head_entry.rgb;
  assign O_RGB_LAST = head_entry.last;

endmodule
